led_fade_driver: RTL and testbench

//   Downstream consumer of the HPS LED PIO export. Turns the 10-bit on/off word written
//   by software into smooth per-LED fade-in/fade-out on the board LEDs (LEDR[9:0]).

---
 rtl/led_fade_driver.sv | 149 ++++++++++++++
 tb/tb_led_fade_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// led_fade_driver
//   Turns the on/off LED word from the HPS PIO into a per-LED brightness that
//   ramps toward full or off at a fixed rate. Each brightness level is then
//   converted into a duty cycle by comparing it against a free-running PWM
//   counter. With fade disabled, the LEDs follow the PIO bits directly, and the
//   levels track the bits so that fade can be re-enabled without a visible step.
module led_fade_driver #(
  parameter int N_LEDS   = 10,
  parameter int LEVEL_W  = 8,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [N_LEDS-1:0] pio_leds_in,
  input  logic              fade_en,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [LEVEL_W-1:0] MAX_LVL   = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] ZERO_LVL  = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W:0]   STEP_EXT  = (LEVEL_W + 1)'(STEP);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE  = TICK_W'(1);
  localparam logic [LEVEL_W-1:0] PWM_ONE   = LEVEL_W'(1);

  // Level plus STEP, computed one bit wider so the sum can never wrap past MAX.
  function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] lvl);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, lvl} + STEP_EXT;
    if (sum > {1'b0, MAX_LVL}) begin
      sat_inc = MAX_LVL;
    end else begin
      sat_inc = sum[LEVEL_W-1:0];
    end
  endfunction

  // Level minus STEP, clamped at zero instead of underflowing.
  function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] lvl);
    logic [LEVEL_W:0] diff;
    if ({1'b0, lvl} < STEP_EXT) begin
      sat_dec = ZERO_LVL;
    end else begin
      diff    = {1'b0, lvl} - STEP_EXT;
      sat_dec = diff[LEVEL_W-1:0];
    end
  endfunction

  logic [N_LEDS-1:0]  pio_q_r;
  logic [LEVEL_W-1:0] level_r     [N_LEDS];
  logic [LEVEL_W-1:0] level_nxt_s [N_LEDS];
  logic [TICK_W-1:0]  tick_cnt_r;
  logic [LEVEL_W-1:0] pwm_cnt_r;
  logic [N_LEDS-1:0]  led_out_r;
  logic [N_LEDS-1:0]  led_nxt_s;
  logic               tick_s;
  logic               busy_s;

  // Ramp tick: one cycle out of every TICK_DIV.
  always_comb begin
    tick_s = 1'b0;
    if (tick_cnt_r == TICK_LAST) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Next brightness levels and next LED drive, for both fade and bypass modes.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      level_nxt_s[i] = level_r[i];
      led_nxt_s[i]   = 1'b0;
      if (fade_en) begin
        led_nxt_s[i] = (level_r[i] == MAX_LVL) || (level_r[i] > pwm_cnt_r);
        if (tick_s) begin
          if (pio_q_r[i]) begin
            level_nxt_s[i] = sat_inc(level_r[i]);
          end else begin
            level_nxt_s[i] = sat_dec(level_r[i]);
          end
        end else begin
          level_nxt_s[i] = level_r[i];
        end
      end else begin
        // Bypass: drive the pin straight from the PIO bit and keep the level
        // parked at the matching end so a later fade starts from there.
        led_nxt_s[i] = pio_q_r[i];
        if (pio_q_r[i]) begin
          level_nxt_s[i] = MAX_LVL;
        end else begin
          level_nxt_s[i] = ZERO_LVL;
        end
      end
    end
  end

  // Busy while any level has not yet reached the end its PIO bit asks for.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (pio_q_r[i]) begin
        if (level_r[i] != MAX_LVL) begin
          busy_s = 1'b1;
        end else begin
          busy_s = busy_s;
        end
      end else begin
        if (level_r[i] != ZERO_LVL) begin
          busy_s = 1'b1;
        end else begin
          busy_s = busy_s;
        end
      end
    end
  end

  // State: input register, levels, prescaler, PWM counter and LED drive.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pio_q_r    <= {N_LEDS{1'b0}};
      tick_cnt_r <= {TICK_W{1'b0}};
      pwm_cnt_r  <= {LEVEL_W{1'b0}};
      led_out_r  <= {N_LEDS{1'b0}};
      for (int i = 0; i < N_LEDS; i++) begin
        level_r[i] <= ZERO_LVL;
      end
    end else begin
      pio_q_r   <= pio_leds_in;
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      led_out_r <= led_nxt_s;
      if (tick_s) begin
        tick_cnt_r <= {TICK_W{1'b0}};
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_ONE;
      end
      for (int i = 0; i < N_LEDS; i++) begin
        level_r[i] <= level_nxt_s[i];
      end
    end
  end

  assign led_out = led_out_r;
  assign busy    = busy_s;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver (LEVEL_W=4, TICK_DIV=64, STEP=4).
// A cycle-level reference model written with plain integer arithmetic is
// compared every cycle; table vectors and directed ramp/duty/bypass sequences
// add hand-derived expectations on top.
module tb_led_fade_driver;

  localparam int N  = 10;
  localparam int LW = 4;
  localparam int TD = 64;
  localparam int ST = 4;
  localparam int MX = 15;

  logic         clk_clk = 1'b0;
  logic         reset_reset;
  logic [N-1:0] pio_leds_in;
  logic         fade_en;
  logic [N-1:0] led_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_lvl [N];
  logic [N-1:0] m_pio_q = '0;
  logic [N-1:0] m_led   = '0;
  int           m_tcnt  = 0;
  int           m_pcnt  = 0;

  typedef struct {
    bit           rst;
    bit           fade;
    logic [N-1:0] pio;
    logic [N-1:0] exp_led;
    bit           exp_busy;
  } vec_t;

  vec_t vecs [14];

  led_fade_driver #(
    .N_LEDS  (N),
    .LEVEL_W (LW),
    .TICK_DIV(TD),
    .STEP    (ST)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .pio_leds_in(pio_leds_in),
    .fade_en    (fade_en),
    .led_out    (led_out),
    .busy       (busy)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    int           nl [N];
    logic [N-1:0] nled;
    bit           tick;
    if (reset_reset) begin
      for (int i = 0; i < N; i++) m_lvl[i] = 0;
      m_pio_q = '0;
      m_led   = '0;
      m_tcnt  = 0;
      m_pcnt  = 0;
    end else begin
      tick = (m_tcnt == TD - 1);
      for (int i = 0; i < N; i++) begin
        if (fade_en) begin
          nled[i] = (m_lvl[i] == MX) || (m_lvl[i] > m_pcnt);
          if (tick) begin
            if (m_pio_q[i]) nl[i] = (m_lvl[i] + ST > MX) ? MX : m_lvl[i] + ST;
            else            nl[i] = (m_lvl[i] - ST < 0)  ? 0  : m_lvl[i] - ST;
          end else begin
            nl[i] = m_lvl[i];
          end
        end else begin
          nled[i] = m_pio_q[i];
          nl[i]   = m_pio_q[i] ? MX : 0;
        end
      end
      for (int i = 0; i < N; i++) m_lvl[i] = nl[i];
      m_led   = nled;
      m_tcnt  = (m_tcnt + 1) % TD;
      m_pcnt  = (m_pcnt + 1) % (MX + 1);
      m_pio_q = pio_leds_in;
    end
  endtask

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_lvl[i] != (m_pio_q[i] ? MX : 0)) b = 1'b1;
    end
    return b;
  endfunction

  // Advance one clock, then compare outputs against the model away from the edge.
  task automatic cycle();
    @(posedge clk_clk);
    model_edge();
    #1;
    check("model_led", 32'(led_out), 32'(m_led));
    check("model_busy", 32'(busy), 32'(model_busy()));
  endtask

  task automatic apply_reset(input int n);
    reset_reset = 1'b1;
    repeat (n) cycle();
    reset_reset = 1'b0;
  endtask

  // Count led_out[0] highs over one full PWM period; also note any activity on 9:1.
  task automatic count_window(output int hi0, output bit rest_zero);
    hi0 = 0;
    rest_zero = 1'b1;
    repeat (16) begin
      cycle();
      hi0 += int'(led_out[0]);
      if (led_out[9:1] != 9'h000) rest_zero = 1'b0;
    end
  endtask

  initial begin
    int hi;
    bit rz;
    int bad;
    for (int i = 0; i < N; i++) m_lvl[i] = 0;

    // Reset: outputs off during reset and right after release.
    reset_reset = 1'b1;
    pio_leds_in = 10'h3FF;
    fade_en     = 1'b1;
    repeat (3) begin
      cycle();
      check("reset_led", 32'(led_out), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
    end
    reset_reset = 1'b0;
    #1;
    check("release_led", 32'(led_out), 32'h0);
    check("release_busy", 32'(busy), 32'h0);
    cycle();
    check("release_led_edge1", 32'(led_out), 32'h0);

    // Table-driven vectors: bypass latency, busy pulse, fade re-entry.
    vecs[0]  = '{1'b1, 1'b0, 10'h000, 10'h000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 10'h2AA, 10'h000, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 10'h2AA, 10'h2AA, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 10'h155, 10'h2AA, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 10'h155, 10'h155, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 10'h3FF, 10'h155, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 10'h000, 10'h3FF, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 10'h3FF, 10'h000, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 10'h3FF, 10'h3FF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 10'h000, 10'h3FF, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 10'h000, 10'h000, 1'b0};
    for (int v = 0; v < 14; v++) begin
      reset_reset = vecs[v].rst;
      fade_en     = vecs[v].fade;
      pio_leds_in = vecs[v].pio;
      cycle();
      check($sformatf("vec%0d_led", v), 32'(led_out), 32'(vecs[v].exp_led));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end

    // Ramp and saturate: 4, 8, 12, then 15 (always on).
    fade_en = 1'b1;
    pio_leds_in = 10'h001;
    apply_reset(2);
    repeat (64) cycle();
    count_window(hi, rz);
    check("duty_lvl4", 32'(hi), 32'd4);
    check("duty_others_off", 32'(rz), 32'd1);
    repeat (48) cycle();
    count_window(hi, rz);
    check("ramp_lvl8", 32'(hi), 32'd8);
    repeat (48) cycle();
    count_window(hi, rz);
    check("ramp_lvl12", 32'(hi), 32'd12);
    repeat (47) cycle();
    check("ramp_busy_before_sat", 32'(busy), 32'd1);
    cycle();
    check("ramp_busy_after_sat", 32'(busy), 32'd0);
    count_window(hi, rz);
    check("ramp_lvl15_on", 32'(hi), 32'd16);
    check("ramp_others_off", 32'(rz), 32'd1);

    // Reversal at level 8: 4 then 0, never rising.
    pio_leds_in = 10'h001;
    apply_reset(2);
    repeat (128) cycle();
    pio_leds_in = 10'h000;
    cycle();
    check("rev_busy", 32'(busy), 32'd1);
    repeat (63) cycle();
    count_window(hi, rz);
    check("rev_lvl4", 32'(hi), 32'd4);
    repeat (47) cycle();
    check("rev_busy_before_zero", 32'(busy), 32'd1);
    cycle();
    check("rev_busy_at_zero", 32'(busy), 32'd0);
    count_window(hi, rz);
    check("rev_lvl0_off", 32'(hi), 32'd0);
    check("rev_others_off", 32'(rz), 32'd1);

    // Bypass: 2-cycle latency, then re-enable fade with no toggling.
    pio_leds_in = 10'h000;
    apply_reset(2);
    repeat (5) cycle();
    fade_en = 1'b0;
    pio_leds_in = 10'h2AA;
    cycle();
    check("byp_led_1cyc", 32'(led_out), 32'h0);
    cycle();
    check("byp_led_2cyc", 32'(led_out), 32'h2AA);
    check("byp_busy", 32'(busy), 32'd0);
    fade_en = 1'b1;
    bad = 0;
    repeat (80) begin
      cycle();
      if (led_out !== 10'h2AA) bad++;
    end
    check("byp_reenable_steady", 32'(bad), 32'd0);

    // Reset mid-ramp at level 8, then the ramp restarts from 0.
    pio_leds_in = 10'h001;
    apply_reset(2);
    repeat (130) cycle();
    reset_reset = 1'b1;
    cycle();
    check("midreset_led", 32'(led_out), 32'h0);
    check("midreset_busy", 32'(busy), 32'd0);
    reset_reset = 1'b0;
    repeat (64) cycle();
    count_window(hi, rz);
    check("midreset_restart_lvl4", 32'(hi), 32'd4);

    // Randomized traffic against the model.
    apply_reset(2);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39, 0) == 0) pio_leds_in = 10'($urandom);
      if ($urandom_range(199, 0) == 0) fade_en = ~fade_en;
      reset_reset = ($urandom_range(499, 0) == 0);
      cycle();
    end
    reset_reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
